// File: rtl/stack_ctrl_if.sv
// Request/response and stack-RAM signals of the stack controller.
// slave is the controller side, master the requester/RAM side.
interface stack_ctrl_if;
    logic        push;
    logic        pop;
    logic [15:0] din;
    logic [15:0] sp;
    logic [15:0] mem_rdata;
    logic        dec;
    logic        inc;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic        mem_we;
    logic        mem_re;
    logic [15:0] dout;
    logic        busy;
    logic        done;
    logic        ovf;
    logic        unf;

    modport slave (
        input  push, pop, din, sp, mem_rdata,
        output dec, inc, mem_addr, mem_wdata, mem_we, mem_re, dout, busy, done, ovf, unf
    );

    modport master (
        output push, pop, din, sp, mem_rdata,
        input  dec, inc, mem_addr, mem_wdata, mem_we, mem_re, dout, busy, done, ovf, unf
    );
endinterface

// File: rtl/stack_ctrl.sv
// Stack push/pop sequencer: writes/reads a stack RAM and pulses SP inc/dec.
// Requests are taken only in IDLE; strobes decode directly from the state.
module stack_ctrl #(
    parameter logic [15:0] SP_TOP   = 16'h01FF,
    parameter logic [15:0] SP_LIMIT = 16'h0000
) (
    input logic        clk,
    input logic        rst,
    stack_ctrl_if.slave bus
);
    localparam int DATA_W = 16;

    typedef enum logic [2:0] {IDLE, PUSH_WR, POP_RD, POP_CAP, DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   sp_q, sp_d;
    logic [DATA_W-1:0]   d_q, d_d;
    logic [DATA_W-1:0]   dout_q, dout_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            sp_q    <= '0;
            d_q     <= '0;
            dout_q  <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            d_q     <= d_d;
            dout_q  <= dout_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        d_d     = d_q;
        dout_d  = dout_q;
        ovf_d   = 1'b0;
        unf_d   = 1'b0;
        case (state_q)
            IDLE: begin
                // Simultaneous push and pop is treated as no request at all.
                if (bus.push && !bus.pop) begin
                    if (bus.sp == SP_LIMIT) begin
                        ovf_d = 1'b1;
                    end else begin
                        sp_d    = bus.sp;
                        d_d     = bus.din;
                        state_d = PUSH_WR;
                    end
                end else if (bus.pop && !bus.push) begin
                    if (bus.sp == SP_TOP) begin
                        unf_d = 1'b1;
                    end else begin
                        sp_d    = bus.sp;
                        state_d = POP_RD;
                    end
                end
            end
            PUSH_WR: state_d = DONE;
            POP_RD:  state_d = POP_CAP;
            POP_CAP: begin
                dout_d  = bus.mem_rdata;
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // SP points at the next free slot, so the top element sits at sp_q+1.
    assign bus.mem_addr  = (state_q == POP_RD) ? sp_q + 16'd1 : sp_q;
    assign bus.mem_wdata = d_q;
    assign bus.mem_we    = (state_q == PUSH_WR);
    assign bus.dec       = (state_q == PUSH_WR);
    assign bus.mem_re    = (state_q == POP_RD);
    assign bus.inc       = (state_q == POP_CAP);
    assign bus.done      = (state_q == DONE);
    assign bus.busy      = (state_q != IDLE);
    assign bus.dout      = dout_q;
    assign bus.ovf       = ovf_q;
    assign bus.unf       = unf_q;
endmodule

// File: tb/tb_stack_ctrl.sv
// Directed bench for stack_ctrl with a RAM model and an expected-access scoreboard.
module tb_stack_ctrl;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    stack_ctrl_if bus ();

    stack_ctrl #(.SP_TOP(16'h01FF), .SP_LIMIT(16'h0000)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        bit          is_pop;
        logic [15:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t        sbq[$];
    logic [15:0] model [logic [15:0]];
    logic [15:0] ram [0:511];
    int          errors = 0;
    int          checks = 0;
    int          wr_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Synchronous stack RAM: read data valid the cycle after mem_re.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr[8:0]] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr[8:0]];
    end

    always @(negedge clk) begin
        if (bus.mem_we || bus.mem_re || bus.inc || bus.done || bus.ovf || bus.unf || bus.dec) begin
            check("excl", 32'(int'(bus.mem_we) + int'(bus.mem_re) + int'(bus.inc) +
                              int'(bus.done) + int'(bus.ovf) + int'(bus.unf)), 32'd1);
            check("dec_we", 32'(bus.dec), 32'(bus.mem_we));
        end
        if (bus.mem_we) begin
            wr_cnt++;
            check("wr_sb_pending", 32'(sbq.size() > 0 && !sbq[0].is_pop), 32'd1);
            if (sbq.size() > 0 && !sbq[0].is_pop) begin
                check("wr_addr", 32'(bus.mem_addr), 32'(sbq[0].addr));
                check("wr_data", 32'(bus.mem_wdata), 32'(sbq[0].data));
                void'(sbq.pop_front());
            end
        end
        if (bus.mem_re) begin
            check("rd_sb_pending", 32'(sbq.size() > 0 && sbq[0].is_pop), 32'd1);
            if (sbq.size() > 0 && sbq[0].is_pop)
                check("rd_addr", 32'(bus.mem_addr), 32'(sbq[0].addr));
        end
        if (bus.done && sbq.size() > 0 && sbq[0].is_pop) begin
            check("pop_dout", 32'(bus.dout), 32'(sbq[0].data));
            void'(sbq.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic exp_push(input logic [15:0] sp_v, input logic [15:0] d_v);
        exp_t e;
        e.is_pop = 1'b0; e.addr = sp_v; e.data = d_v;
        sbq.push_back(e);
        model[sp_v] = d_v;
    endtask

    task automatic exp_pop(input logic [15:0] sp_v);
        exp_t e;
        logic [15:0] a;
        a = sp_v + 16'd1;
        e.is_pop = 1'b1; e.addr = a; e.data = model.exists(a) ? model[a] : 16'h0000;
        sbq.push_back(e);
    endtask

    initial begin
        rst = 1'b0;
        bus.push = 1'b0; bus.pop = 1'b0; bus.din = '0; bus.sp = 16'h01FF;
        tick(); tick();
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_dout", 32'(bus.dout), 32'd0);
        check("rst_addr", 32'(bus.mem_addr), 32'd0);
        check("rst_wdata", 32'(bus.mem_wdata), 32'd0);
        check("rst_strobes", 32'({bus.mem_we, bus.mem_re, bus.dec, bus.inc, bus.done, bus.ovf, bus.unf}), 32'd0);
        rst = 1'b1;

        // Push ABCD at 01FF; sp changes mid-operation must not matter.
        bus.sp = 16'h01FF; bus.din = 16'hABCD; bus.push = 1'b1;
        exp_push(16'h01FF, 16'hABCD);
        tick();
        bus.push = 1'b0; bus.sp = 16'h0042; bus.din = 16'h0000;
        check("p1_we", 32'(bus.mem_we), 32'd1);
        check("p1_dec", 32'(bus.dec), 32'd1);
        check("p1_addr", 32'(bus.mem_addr), 32'h01FF);
        check("p1_wdata", 32'(bus.mem_wdata), 32'hABCD);
        check("p1_busy", 32'(bus.busy), 32'd1);
        check("p1_done_early", 32'(bus.done), 32'd0);
        tick();
        check("p1_done", 32'(bus.done), 32'd1);
        check("p1_we_off", 32'(bus.mem_we), 32'd0);
        tick();
        check("p1_idle", 32'({bus.busy, bus.done}), 32'd0);

        // push=pop=1 is ignored.
        bus.sp = 16'h01FF; bus.push = 1'b1; bus.pop = 1'b1;
        tick();
        check("both_busy", 32'(bus.busy), 32'd0);
        check("both_flags", 32'({bus.ovf, bus.unf}), 32'd0);
        // Push 1234; push held through PUSH_WR must not start a second op.
        bus.pop = 1'b0; bus.din = 16'h1234;
        exp_push(16'h01FF, 16'h1234);
        tick();
        bus.din = 16'h5555;
        check("p2_we", 32'(bus.mem_we), 32'd1);
        check("p2_wdata", 32'(bus.mem_wdata), 32'h1234);
        tick();
        check("p2_done", 32'(bus.done), 32'd1);
        bus.push = 1'b0;
        tick();
        check("p2_idle", 32'(bus.busy), 32'd0);
        check("p2_wr_cnt", 32'(wr_cnt), 32'd2);

        // Pop at 01FE reads 01FF.
        bus.sp = 16'h01FE; bus.pop = 1'b1;
        exp_pop(16'h01FE);
        tick();
        bus.pop = 1'b0;
        check("pop_re", 32'(bus.mem_re), 32'd1);
        check("pop_addr", 32'(bus.mem_addr), 32'h01FF);
        check("pop_inc_early", 32'(bus.inc), 32'd0);
        tick();
        check("pop_inc", 32'(bus.inc), 32'd1);
        check("pop_re_off", 32'(bus.mem_re), 32'd0);
        tick();
        check("pop_done", 32'(bus.done), 32'd1);
        check("pop_dout", 32'(bus.dout), 32'h1234);
        tick();
        check("pop_idle", 32'(bus.busy), 32'd0);

        // Underflow at SP_TOP.
        bus.sp = 16'h01FF; bus.pop = 1'b1;
        tick();
        bus.pop = 1'b0;
        check("unf_pulse", 32'(bus.unf), 32'd1);
        check("unf_quiet", 32'({bus.busy, bus.mem_re, bus.inc}), 32'd0);
        tick();
        check("unf_clear", 32'({bus.unf, bus.busy, bus.mem_re, bus.inc}), 32'd0);

        // Overflow at SP_LIMIT.
        bus.sp = 16'h0000; bus.din = 16'hFFFF; bus.push = 1'b1;
        tick();
        bus.push = 1'b0;
        check("ovf_pulse", 32'(bus.ovf), 32'd1);
        check("ovf_quiet", 32'({bus.busy, bus.mem_we, bus.dec}), 32'd0);
        tick();
        check("ovf_clear", 32'({bus.ovf, bus.mem_we, bus.dec}), 32'd0);

        // Push one above the limit is still legal.
        bus.sp = 16'h0001; bus.din = 16'h0F0F; bus.push = 1'b1;
        exp_push(16'h0001, 16'h0F0F);
        tick();
        bus.push = 1'b0;
        check("lim_we", 32'(bus.mem_we), 32'd1);
        check("lim_addr", 32'(bus.mem_addr), 32'h0001);
        tick(); tick();
        check("lim_wr_cnt", 32'(wr_cnt), 32'd3);

        // Reset during POP_RD aborts the pop.
        bus.sp = 16'h01FE; bus.pop = 1'b1;
        exp_pop(16'h01FE);
        tick();
        bus.pop = 1'b0;
        check("ab_re", 32'(bus.mem_re), 32'd1);
        rst = 1'b0;
        tick();
        rst = 1'b1;
        sbq.delete();
        check("ab_busy", 32'(bus.busy), 32'd0);
        check("ab_dout", 32'(bus.dout), 32'd0);
        check("ab_addr", 32'(bus.mem_addr), 32'd0);
        check("ab_strobes", 32'({bus.inc, bus.done, bus.mem_re}), 32'd0);
        tick();
        check("ab_after", 32'({bus.inc, bus.done, bus.busy}), 32'd0);
        tick();

        check("sb_empty", 32'(sbq.size()), 32'd0);
        check("wr_total", 32'(wr_cnt), 32'd3);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
